rp_output_capture: RTL
======================

# rp_output_capture

Static-side capture and isolation stage for the outputs of a reconfigurable partition. It registers NUM_CH channels of CH_W bits each from the RP into static logic and isolates static logic from RP outputs while the partition is being reconfigured. After isolation it holds the last value or drives a safe constant, and it re-couples only after a programmable settle interval. It sits between the RP instance and the static output registers/pins, and generalises the fixed two-channel 4-bit output register to a parametrised, decoupling-aware block.

## Interface
- NUM_CH, 2: number of output channels (1..16).
- CH_W, 4: bits per channel (1..32).
- SETTLE_CYCLES, 16: cycles outputs stay isolated after decouple_req falls (0..65535; 0 = re-couple immediately).
- HOLD_MODE, 1: while isolated; 1 = hold last captured value, 0 = drive SAFE_VALUE.
- SAFE_VALUE, 0: CH_W-bit constant driven on every channel when HOLD_MODE = 0 and isolated.

- gclk, in, 1: clock. Reset rst, synchronous, active-high; clock gclk.
- rst, in, 1: synchronous active-high reset.
- decouple_req, in, 1: level request from the reconfiguration controller to isolate the RP.
- ch_en, in, NUM_CH: per-channel capture enable; a disabled channel holds its current output.
- rp_data, in, NUM_CH*CH_W: RP outputs; channel i is bits [i*CH_W +: CH_W].
- out_data, out, NUM_CH*CH_W: registered outputs to static logic.
- decouple_ack, out, 1: high while outputs are isolated (DECOUPLED or SETTLE).
- reconfig_count, out, 8: saturating count of completed decouple episodes.

## Operation
- Reset values: out_data = all zeros, regardless of HOLD_MODE and SAFE_VALUE. decouple_ack = 0, reconfig_count = 0, state = COUPLED, settle counter = 0.
- States:
  - COUPLED: for each channel i with ch_en[i] = 1, out_data[i] <= rp_data[i]. Otherwise the channel holds.
  - DECOUPLED: rp_data is ignored on all channels. HOLD_MODE = 1 holds out_data. HOLD_MODE = 0 loads SAFE_VALUE into every channel on the entry edge and keeps it. ch_en is ignored.
  - SETTLE: same output behaviour as DECOUPLED; the settle counter decrements each cycle.
- Transitions:
  - COUPLED -> DECOUPLED when decouple_req = 1.
  - DECOUPLED -> SETTLE when decouple_req = 0. The counter loads SETTLE_CYCLES-1.
  - If SETTLE_CYCLES = 0, DECOUPLED goes directly to COUPLED.
  - SETTLE -> COUPLED when counter = 0 and decouple_req = 0.
  - SETTLE -> DECOUPLED when decouple_req = 1. The counter clears, so a fresh full settle interval is required next time.
- reconfig_count increments by 1 on each SETTLE -> COUPLED transition, or DECOUPLED -> COUPLED when SETTLE_CYCLES = 0. It saturates at 255 and does not wrap.
- The settle counter is ceil(log2(SETTLE_CYCLES+1)) bits wide, minimum 1. There is no wrap; it only decrements while nonzero.

## Timing
- COUPLED data latency: 1 cycle from rp_data to out_data.
- Isolation latency, decouple_req rising at edge N:
  - The state is DECOUPLED after edge N.
  - decouple_ack = 1 and out_data is frozen (or SAFE_VALUE) from edge N onward.
  - The rp_data sampled at edge N is not captured.
- Re-couple, decouple_req falling (sampled low) at edge M:
  - decouple_ack stays 1 through edge M+SETTLE_CYCLES and falls after that edge.
  - The first capture of rp_data happens at edge M+SETTLE_CYCLES+1.
- With SETTLE_CYCLES = 0: ack falls after edge M and capture resumes at edge M+1.
- rst overrides everything, including mid-SETTLE and mid-DECOUPLED. Outputs return to reset values on the next edge.
- decouple_req is assumed synchronous to gclk. Synchronisation is the controller's responsibility.

## Structure
- Package rp_capture_pkg holds:
  - state enum {COUPLED, DECOUPLED, SETTLE} as a 2-bit encoding;
  - a function computing the settle counter width from SETTLE_CYCLES;
  - the constant RECONFIG_CNT_W = 8.
- Sub-module rp_settle_timer: load / decrement / zero-flag counter parametrised by SETTLE_CYCLES, instantiated once.
- Per-channel capture is a generate loop in rp_output_capture.

## Test plan
- Reset, then stream rp_data = 0xA5 (NUM_CH = 2, CH_W = 4) with ch_en = 2'b11 -> out_data = 0x00 during reset and 0xA5 one cycle after the first post-reset edge. decouple_ack = 0.
- HOLD_MODE = 1, SETTLE_CYCLES = 4: capture 0x3C, raise decouple_req for 10 cycles while rp_data toggles randomly, then drop it -> out_data stays 0x3C. ack falls 4 cycles after req falls. The next rp_data is captured one cycle later. reconfig_count = 1.
- HOLD_MODE = 0, SAFE_VALUE = 4'h5: raise decouple_req -> out_data = 0x55 on the next edge. It stays 0x55 through SETTLE, then follows rp_data.
- SETTLE_CYCLES = 8: re-assert decouple_req at settle cycle 5 and release it again -> the state returns to DECOUPLED, then a full 8-cycle settle. ack is never low in between. reconfig_count increments only once.
- ch_en = 2'b01 with rp_data changing both nibbles -> only the low nibble updates and the high nibble holds. Assert rst mid-SETTLE -> out_data = 0 and ack = 0 next cycle.
- 300 decouple episodes with SETTLE_CYCLES = 0 -> reconfig_count saturates at 255. Each episode shows ack high for exactly the req-high duration.

Source files
------------

// File: rtl/rp_capture_pkg.sv
// Shared definitions for the RP output capture/isolation stage.
//   cap_state_t    : coupling state of the capture stage
//   settle_cnt_w() : settle counter width for a given settle interval
//   RECONFIG_CNT_W : width of the completed-episode counter
package rp_capture_pkg;

   typedef enum logic [1:0] {
      COUPLED   = 2'd0,
      DECOUPLED = 2'd1,
      SETTLE    = 2'd2
   } cap_state_t;

   localparam int RECONFIG_CNT_W = 8;

   // ceil(log2(settle_cycles+1)), never less than one bit
   function automatic int settle_cnt_w(input int settle_cycles);
      int w;
      w = $clog2(settle_cycles + 1);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/rp_settle_timer.sv
// Settle interval down-counter.
//   gclk  : clock
//   rst   : synchronous active-high reset (count -> 0)
//   load  : load SETTLE_CYCLES-1
//   clear : force count to 0 (takes priority over load)
//   dec   : decrement; the count never wraps below zero
//   zero  : count is zero
module rp_settle_timer
   import rp_capture_pkg::*;
#(
   parameter int SETTLE_CYCLES = 16
) (
   input  logic gclk,
   input  logic rst,
   input  logic load,
   input  logic clear,
   input  logic dec,
   output logic zero
);

   localparam int CNT_W = settle_cnt_w(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] LOAD_VAL =
      (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge gclk) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (load)
         cnt <= LOAD_VAL;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/rp_output_capture.sv
// Static-side capture and isolation of reconfigurable-partition outputs.
//
// state     | meaning
// ----------|-------------------------------------------------------------
// COUPLED   | enabled channels register rp_data every cycle
// DECOUPLED | RP isolated; outputs hold (or SAFE_VALUE); waiting for req low
// SETTLE    | still isolated; settle timer runs down before re-coupling
//
// Ports:
//   gclk, rst       : clock, synchronous active-high reset
//   decouple_req    : level isolation request from the reconfig controller
//   ch_en           : per-channel capture enable (COUPLED only)
//   rp_data         : RP outputs, channel i at [i*CH_W +: CH_W]
//   out_data        : registered outputs to static logic
//   decouple_ack    : high while isolated (DECOUPLED or SETTLE)
//   reconfig_count  : saturating count of completed decouple episodes
module rp_output_capture
   import rp_capture_pkg::*;
#(
   parameter int              NUM_CH        = 2,
   parameter int              CH_W          = 4,
   parameter int              SETTLE_CYCLES = 16,
   parameter int              HOLD_MODE     = 1,
   parameter logic [CH_W-1:0] SAFE_VALUE    = '0
) (
   input  logic                      gclk,
   input  logic                      rst,
   input  logic                      decouple_req,
   input  logic [NUM_CH-1:0]         ch_en,
   input  logic [NUM_CH*CH_W-1:0]    rp_data,
   output logic [NUM_CH*CH_W-1:0]    out_data,
   output logic                      decouple_ack,
   output logic [RECONFIG_CNT_W-1:0] reconfig_count
);

   cap_state_t state, state_nxt;
   logic       t_load, t_clear, t_dec, t_zero;
   logic       recouple;
   logic       capture_go;
   logic       safe_load;
   logic [NUM_CH*CH_W-1:0] out_nxt;

   rp_settle_timer #(
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_settle_timer (
      .gclk  (gclk),
      .rst   (rst),
      .load  (t_load),
      .clear (t_clear),
      .dec   (t_dec),
      .zero  (t_zero)
   );

   always_ff @(posedge gclk) begin
      if (rst)
         state <= COUPLED;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      t_load    = 1'b0;
      t_clear   = 1'b0;
      t_dec     = 1'b0;
      recouple  = 1'b0;
      case (state)
         COUPLED: begin
            if (decouple_req)
               state_nxt = DECOUPLED;
         end
         DECOUPLED: begin
            if (!decouple_req) begin
               if (SETTLE_CYCLES == 0) begin
                  state_nxt = COUPLED;
                  recouple  = 1'b1;
               end else begin
                  state_nxt = SETTLE;
                  t_load    = 1'b1;
               end
            end
         end
         SETTLE: begin
            // A new request restarts the whole settle interval later on.
            if (decouple_req) begin
               state_nxt = DECOUPLED;
               t_clear   = 1'b1;
            end else if (t_zero) begin
               state_nxt = COUPLED;
               recouple  = 1'b1;
            end else begin
               t_dec = 1'b1;
            end
         end
         default: state_nxt = COUPLED;
      endcase
   end

   // The request edge itself must not capture: isolation is effective at
   // the same edge that moves the state to DECOUPLED.
   assign capture_go = (state == COUPLED) && !decouple_req;
   assign safe_load  = (state == COUPLED) && decouple_req && (HOLD_MODE == 0);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign out_nxt[i*CH_W +: CH_W] =
         safe_load                ? SAFE_VALUE :
         (capture_go && ch_en[i]) ? rp_data[i*CH_W +: CH_W] :
                                    out_data[i*CH_W +: CH_W];
   end

   always_ff @(posedge gclk) begin
      if (rst)
         out_data <= '0;
      else
         out_data <= out_nxt;
   end

   always_ff @(posedge gclk) begin
      if (rst)
         reconfig_count <= '0;
      else if (recouple && (reconfig_count != '1))
         reconfig_count <= reconfig_count + 1'b1;
   end

   assign decouple_ack = (state != COUPLED);

endmodule
